// File: rtl/stopwatch_counter.sv
// Stopwatch time base: centisecond prescaler, SS.cc BCD counter under a
// start/stop/clear FSM, and registered active-high 7-segment digit encoding.
module stopwatch_counter #(
  parameter int unsigned TICK_DIV      = 1_000_000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        clear,
  output logic        running,
  output logic [15:0] bcd_value,
  output logic [6:0]  digit0_segments,
  output logic [6:0]  digit1_segments,
  output logic [6:0]  digit2_segments,
  output logic [6:0]  digit3_segments
);

  localparam int unsigned     PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   bcd_p0, bcd_d;
  logic          tick;
  logic [6:0]    seg0_p1, seg1_p1, seg2_p1, seg3_p1;

  function automatic logic [6:0] seg7_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Ripple-carry BCD increment; 59.99 wraps to 00.00.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (v[11:8] != 4'd9) begin
          r[11:8] = v[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = (v[15:12] != 4'd5) ? v[15:12] + 4'd1 : 4'd0;
        end
      end
    end
    return r;
  endfunction

  assign tick = (state_q == RUNNING) && (presc_q == PRESC_MAX);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    bcd_d   = bcd_p0;
    if (clear) begin
      state_d = IDLE;
      presc_d = '0;
      bcd_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_stop) begin
            state_d = RUNNING;
            presc_d = '0;
          end
        end
        RUNNING: begin
          if (tick) begin
            bcd_d   = bcd_inc(bcd_p0);
            presc_d = '0;
          end else if (!start_stop) begin
            presc_d = presc_q + PW'(1);
          end
          if (start_stop) state_d = PAUSED;
        end
        PAUSED: begin
          if (start_stop) state_d = RUNNING;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage p0: control state, prescaler and BCD count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      bcd_p0  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      bcd_p0  <= bcd_d;
    end
  end

  // Stage p1: segment patterns from the registered count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg0_p1 <= 7'h3F;
      seg1_p1 <= 7'h3F;
      seg2_p1 <= 7'h3F;
      seg3_p1 <= BLANK_LEADING ? 7'h00 : 7'h3F;
    end else begin
      seg0_p1 <= seg7_encode(bcd_p0[3:0]);
      seg1_p1 <= seg7_encode(bcd_p0[7:4]);
      seg2_p1 <= seg7_encode(bcd_p0[11:8]);
      seg3_p1 <= (BLANK_LEADING && (bcd_p0[15:12] == 4'd0)) ? 7'h00
                                                            : seg7_encode(bcd_p0[15:12]);
    end
  end

  assign running         = (state_q == RUNNING);
  assign bcd_value       = bcd_p0;
  assign digit0_segments = seg0_p1;
  assign digit1_segments = seg1_p1;
  assign digit2_segments = seg2_p1;
  assign digit3_segments = seg3_p1;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: centisecond-count reference model, directed
// scenarios and randomized start/stop/clear traffic.
module tb_stopwatch_counter;

  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        running;
  logic [15:0] bcd_value;
  logic [6:0]  digit0_segments, digit1_segments, digit2_segments, digit3_segments;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: elapsed centiseconds, clocks into current period, mode
  int m_cs = 0;
  int m_phase = 0;
  int m_mode = 0;   // 0 idle, 1 running, 2 paused
  int m_seg_cs = 0; // count the segment registers currently display

  logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  stopwatch_counter #(.TICK_DIV(TICK_DIV), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear),
    .running(running), .bcd_value(bcd_value),
    .digit0_segments(digit0_segments), .digit1_segments(digit1_segments),
    .digit2_segments(digit2_segments), .digit3_segments(digit3_segments)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] cs_to_bcd(input int cs);
    return {4'(cs / 1000), 4'((cs / 100) % 10), 4'((cs / 10) % 10), 4'(cs % 10)};
  endfunction

  task automatic check_all();
    chk("bcd", 32'(bcd_value), 32'(cs_to_bcd(m_cs)));
    chk("running", 32'(running), 32'(m_mode == 1));
    chk("digit0", 32'(digit0_segments), 32'(seg_tab[m_seg_cs % 10]));
    chk("digit1", 32'(digit1_segments), 32'(seg_tab[(m_seg_cs / 10) % 10]));
    chk("digit2", 32'(digit2_segments), 32'(seg_tab[(m_seg_cs / 100) % 10]));
    chk("digit3", 32'(digit3_segments),
        (m_seg_cs / 1000 == 0) ? 32'h00 : 32'(seg_tab[m_seg_cs / 1000]));
  endtask

  task automatic model_reset();
    m_cs = 0; m_phase = 0; m_mode = 0; m_seg_cs = 0;
  endtask

  task automatic model_edge(input logic ss, input logic clr);
    m_seg_cs = m_cs;
    if (clr) begin
      m_mode = 0; m_cs = 0; m_phase = 0;
    end else if (m_mode == 0) begin
      if (ss) begin m_mode = 1; m_phase = 0; end
    end else if (m_mode == 1) begin
      if (m_phase == TICK_DIV - 1) begin
        m_cs = (m_cs + 1) % 6000;
        m_phase = 0;
      end else if (!ss) begin
        m_phase++;
      end
      if (ss) m_mode = 2;
    end else begin
      if (ss) m_mode = 1;
    end
  endtask

  task automatic step(input logic ss, input logic clr);
    start_stop = ss;
    clear = clr;
    @(posedge clk);
    model_edge(ss, clr);
    #1;
    start_stop = 1'b0;
    clear = 1'b0;
    check_all();
  endtask

  task automatic run_until(input int target);
    int n;
    n = 0;
    while (m_cs != target && n < 30000) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk("reach_target", 32'(bcd_value), 32'(cs_to_bcd(target)));
  endtask

  logic [15:0] held;

  initial begin
    // Reset values while rst_n is held low
    #12;
    chk("rst_bcd", 32'(bcd_value), 32'h0000);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_d0", 32'(digit0_segments), 32'h3F);
    chk("rst_d3", 32'(digit3_segments), 32'h00);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check_all();
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0);

    // First increment after start: E0+TICK_DIV; segments one cycle later
    step(1'b1, 1'b0);
    chk("start_running", 32'(running), 32'h1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    chk("pre_tick_bcd", 32'(bcd_value), 32'h0000);
    step(1'b0, 1'b0);
    chk("first_tick_bcd", 32'(bcd_value), 32'h0001);
    chk("d0_lag", 32'(digit0_segments), 32'h3F);
    step(1'b0, 1'b0);
    chk("d0_one", 32'(digit0_segments), 32'h06);
    run_until(10);

    // Full wrap 59.99 -> 00.00 stays running, then seconds-tens = 1
    run_until(5999);
    while (m_cs == 5999) step(1'b0, 1'b0);
    chk("wrap_bcd", 32'(bcd_value), 32'h0000);
    chk("wrap_running", 32'(running), 32'h1);
    step(1'b0, 1'b0);
    chk("wrap_d3", 32'(digit3_segments), 32'h00);
    chk("wrap_d0", 32'(digit0_segments), 32'h3F);
    run_until(1000);
    step(1'b0, 1'b0);
    chk("tens1_d3", 32'(digit3_segments), 32'h06);

    // Pause at prescaler 2, hold 50 cycles, resume: increment 2 cycles later
    for (int i = 0; i < 8 && !(m_mode == 1 && m_phase == 2); i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    held = bcd_value;
    chk("pause_running", 32'(running), 32'h0);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
    chk("pause_hold", 32'(bcd_value), 32'(held));
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("resume_1", 32'(bcd_value), 32'(held));
    step(1'b0, 1'b0);
    chk("resume_2", 32'(bcd_value), 32'(cs_to_bcd(m_cs)));
    chk("resume_inc", 32'(bcd_value == held), 32'h0);

    // clear + start_stop together at 12.34 while running
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    run_until(1234);
    step(1'b1, 1'b1);
    chk("clr_pri_bcd", 32'(bcd_value), 32'h0000);
    chk("clr_pri_running", 32'(running), 32'h0);

    // start_stop on a tick: increment applied, then paused, no more counting
    step(1'b1, 1'b0);
    while (m_phase != TICK_DIV - 1) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("ss_tick_bcd", 32'(bcd_value), 32'h0001);
    chk("ss_tick_running", 32'(running), 32'h0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    chk("ss_tick_hold", 32'(bcd_value), 32'h0001);

    // Asynchronous reset mid-run at 04.57
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    run_until(457);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_bcd", 32'(bcd_value), 32'h0000);
    chk("arst_running", 32'(running), 32'h0);
    chk("arst_d0", 32'(digit0_segments), 32'h3F);
    chk("arst_d1", 32'(digit1_segments), 32'h3F);
    chk("arst_d2", 32'(digit2_segments), 32'h3F);
    chk("arst_d3", 32'(digit3_segments), 32'h00);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    chk("post_rst_idle", 32'(bcd_value), 32'h0000);

    // Randomized start/stop/clear traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
